divider: RTL and testbench
==========================

# divider

Iterative 32-bit integer divider for the RV32M DIV, DIVU, REM and REMU instructions. It sits beside the multiplier in the execute stage and receives the same decoded opcode and operand bundle. It produces one quotient or remainder per accepted instruction after a fixed multi-cycle latency. `busy_o` tells the issue logic to stall further divide instructions while an operation is in flight.

## Interface
- No parameters; datapath width fixed at 32.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `opcode_valid_i` in 1: opcode bundle valid this cycle.
- `opcode_opcode_i` in 32: raw instruction word.
- `opcode_rd_idx_i` in 5: destination register index.
- `opcode_ra_operand_i` in 32: rs1 value (dividend).
- `opcode_rb_operand_i` in 32: rs2 value (divisor).
- `hold_i` in 1: pipeline stall; freezes all state.
- `flush_i` in 1: abort any in-flight operation.
- `busy_o` out 1: operation in flight; new divides are not accepted.
- `writeback_valid_o` out 1: one-cycle result strobe.
- `writeback_rd_idx_o` out 5: rd of the completing operation.
- `writeback_value_o` out 32: quotient or remainder.

## Operation
- Decode uses mask `0xFE00707F`. The four matches are DIV `0x02004033`, DIVU `0x02005033`, REM `0x02006033` and REMU `0x02007033`.
- Accept condition: IDLE & `opcode_valid_i` & divide match & ~`hold_i` & ~`flush_i`. Any other instruction is ignored.
- On accept, latch the following:
  - `|a|` and `|b|`, where the absolute value is taken only for DIV/REM with sign bit 1.
  - Sign flags: `q_neg = a[31]^b[31]` (signed ops, b≠0); `r_neg = a[31]` (signed ops).
  - `rem_sel` and `rd_idx`.
- States:
  - IDLE → RUN on accept; iteration counter loads 31.
  - RUN → DONE when the counter equals 0 at the iteration edge.
  - DONE → IDLE unconditionally.
  - `flush_i` forces any state → IDLE (takes priority over everything except reset).
  - `hold_i` = 1 freezes state, counter and datapath; `flush_i` still wins.
- Iteration (restoring, one quotient bit per edge):
  - `{r,q} <= {r,q} << 1`.
  - Trial subtract `r' = {r[31:0],q[31]} - {1'b0,|b|}`, computed at 33 bits.
  - If no borrow, `r <= r'[31:0]` and `q[0] <= 1`.
- Result in DONE:
  - Quotient = `q_neg ? -q : q`; remainder = `r_neg ? -r : r`, both modulo 2^32.
  - `writeback_value_o` = remainder if `rem_sel`, else quotient.
- Boundary results, which fall out of the algorithm with no special path:
  - Divide by zero: quotient `0xFFFFFFFF`; remainder = dividend; holds for signed and unsigned.
  - Overflow `0x80000000 / 0xFFFFFFFF` (DIV): quotient `0x80000000`, remainder 0.
- `busy_o = (state != IDLE)`.
- `writeback_valid_o = (state == DONE)`; `writeback_rd_idx_o` and `writeback_value_o` are meaningful only while it is high.

## Timing
- Reset values: state IDLE, `busy_o` 0, `writeback_valid_o` 0, `writeback_rd_idx_o` 0, `writeback_value_o` 0, all internal registers 0.
- Let the accept edge be A. Iterations occur on edges A+1 … A+32. DONE occupies the cycle after edge A+32, so `writeback_valid_o` rises 32 edges after accept, with no hold.
- Each cycle with `hold_i` high adds exactly one cycle of latency. DONE held under `hold_i` keeps `writeback_valid_o` high until released.
- Back-to-back operation: a divide presented during DONE is not accepted, because the state is not IDLE. The earliest next accept is the cycle after DONE, giving a throughput of one op per 34 cycles.
- `flush_i` in any RUN cycle:
  - Next cycle is IDLE, with no writeback strobe.
  - A same-cycle new opcode is not accepted.
- `flush_i` during DONE suppresses nothing already visible in that cycle. The next cycle is IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- DIVU `100 / 7` → after 32 edges, `writeback_valid_o` = 1 for one cycle, value 14; REMU of the same operands → 2.
- DIV `-100 / 7` → `0xFFFFFFF2` (−14); REM → `0xFFFFFFFE` (−2); DIV `100 / -7` → −14; REM → 2.
- Divide by zero: DIV `-5 / 0` → `0xFFFFFFFF`; REM → `0xFFFFFFFB`; DIVU `0x12345678 / 0` → `0xFFFFFFFF`.
- Overflow: DIV `0x80000000 / 0xFFFFFFFF` → `0x80000000`; REM → 0.
- Hold `hold_i` high for 5 cycles mid-RUN on DIVU `0xFFFFFFFF / 1` → strobe 37 edges after accept, value `0xFFFFFFFF`, `rd_idx` preserved.
- Issue DIV, assert `flush_i` at iteration 10 → no strobe, `busy_o` = 0 next cycle. Then a new DIVU `9 / 3` is accepted and returns 3. Deassert `rst_ni` mid-RUN → outputs 0 asynchronously.

Source files
------------

// File: rtl/divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; 32 iterations after accept, then a one-cycle DONE strobe.
module divider (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_idx_o,
    output logic [31:0] writeback_value_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [31:0] DecodeMask = 32'hFE00707F;
    localparam logic [31:0] MatchDiv   = 32'h02004033;
    localparam logic [31:0] MatchDivu  = 32'h02005033;
    localparam logic [31:0] MatchRem   = 32'h02006033;
    localparam logic [31:0] MatchRemu  = 32'h02007033;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] r_q;
    logic [31:0] q_q;
    logic [31:0] b_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        rem_sel_q;
    logic [4:0]  rd_idx_q;

    logic [31:0] masked;
    logic        is_div;
    logic        op_signed;
    logic        accept;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // Decode the opcode bundle and prepare operand magnitudes for accept.
    always_comb begin
        masked    = opcode_opcode_i & DecodeMask;
        is_div    = (masked == MatchDiv) || (masked == MatchDivu) ||
                    (masked == MatchRem) || (masked == MatchRemu);
        // funct3[0] clear selects the signed variants (DIV, REM).
        op_signed = ~opcode_opcode_i[12];
        accept    = (state_q == StIdle) && opcode_valid_i && is_div && !hold_i && !flush_i;
        abs_a     = (op_signed && opcode_ra_operand_i[31]) ? (32'd0 - opcode_ra_operand_i)
                                                           : opcode_ra_operand_i;
        abs_b     = (op_signed && opcode_rb_operand_i[31]) ? (32'd0 - opcode_rb_operand_i)
                                                           : opcode_rb_operand_i;
    end

    // Trial subtraction of the shifted partial remainder; bit 32 is the borrow.
    always_comb begin
        trial = {r_q, q_q[31]} - {1'b0, b_q};
    end

    // Control FSM and datapath: accept, iterate, complete; flush beats hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            r_q       <= 32'd0;
            q_q       <= 32'd0;
            b_q       <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            rd_idx_q  <= 5'd0;
        end else if (flush_i) begin
            state_q <= StIdle;
        end else if (!hold_i) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q   <= StRun;
                        cnt_q     <= 5'd31;
                        r_q       <= 32'd0;
                        q_q       <= abs_a;
                        b_q       <= abs_b;
                        q_neg_q   <= op_signed &&
                                     (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31]) &&
                                     (opcode_rb_operand_i != 32'd0);
                        r_neg_q   <= op_signed && opcode_ra_operand_i[31];
                        rem_sel_q <= opcode_opcode_i[13];
                        rd_idx_q  <= opcode_rd_idx_i;
                    end
                end
                StRun: begin
                    if (!trial[32]) begin
                        r_q <= trial[31:0];
                        q_q <= {q_q[30:0], 1'b1};
                    end else begin
                        r_q <= {r_q[30:0], q_q[31]};
                        q_q <= {q_q[30:0], 1'b0};
                    end
                    if (cnt_q == 5'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Sign-correct the result; outputs read as zero outside DONE.
    always_comb begin
        quotient           = q_neg_q ? (32'd0 - q_q) : q_q;
        remainder          = r_neg_q ? (32'd0 - r_q) : r_q;
        busy_o             = (state_q != StIdle);
        writeback_valid_o  = (state_q == StDone);
        writeback_rd_idx_o = writeback_valid_o ? rd_idx_q : 5'd0;
        writeback_value_o  = writeback_valid_o ? (rem_sel_q ? remainder : quotient) : 32'd0;
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a negedge monitor checks them.
module tb_divider;

    logic        clk_i;
    logic        rst_ni;
    logic        opcode_valid_i;
    logic [31:0] opcode_opcode_i;
    logic [4:0]  opcode_rd_idx_i;
    logic [31:0] opcode_ra_operand_i;
    logic [31:0] opcode_rb_operand_i;
    logic        hold_i;
    logic        flush_i;
    logic        busy_o;
    logic        writeback_valid_o;
    logic [4:0]  writeback_rd_idx_o;
    logic [31:0] writeback_value_o;

    divider dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .opcode_valid_i     (opcode_valid_i),
        .opcode_opcode_i    (opcode_opcode_i),
        .opcode_rd_idx_i    (opcode_rd_idx_i),
        .opcode_ra_operand_i(opcode_ra_operand_i),
        .opcode_rb_operand_i(opcode_rb_operand_i),
        .hold_i             (hold_i),
        .flush_i            (flush_i),
        .busy_o             (busy_o),
        .writeback_valid_o  (writeback_valid_o),
        .writeback_rd_idx_o (writeback_rd_idx_o),
        .writeback_value_o  (writeback_value_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    localparam logic [1:0] OpDiv = 2'd0, OpDivu = 2'd1, OpRem = 2'd2, OpRemu = 2'd3;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural RV32M result computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (op[0]) begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end else begin
            sa = $signed(a);
            sb = $signed(b);
        end
        if (b == 32'd0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rd);
        return 32'h02004033 | (32'(op) << 12) | (32'(rd) << 7) | ($urandom & 32'h01FF8000);
    endfunction

    function automatic logic [31:0] pick();
        int unsigned s;
        s = $urandom_range(0, 5);
        case (s)
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one divide when idle; called and returns at posedge+1.
    task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input int unsigned lat, input bit track);
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (busy_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_wait: busy_o stuck at 1 expected 0");
        end
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = enc(op, rd);
        opcode_rd_idx_i     = rd;
        opcode_ra_operand_i = a;
        opcode_rb_operand_i = b;
        @(posedge clk_i);
        #1;
        opcode_valid_i = 1'b0;
        if (track) sb_q.push_back('{rd, ref_div(op, a, b), cyc + lat});
        chk("busy_after_accept", 32'(busy_o), 32'd1);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && writeback_valid_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got value %h rd %0d expected no strobe",
                         writeback_value_o, writeback_rd_idx_o);
            end else begin
                e = sb_q.pop_front();
                chk("wb_value", writeback_value_o, e.val);
                chk("wb_rd", 32'(writeback_rd_idx_o), 32'(e.rd));
                chk("wb_latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int d;
        int n;
        cyc                 = 0;
        n_checks            = 0;
        n_fail              = 0;
        rst_ni              = 1'b0;
        opcode_valid_i      = 1'b0;
        opcode_opcode_i     = 32'd0;
        opcode_rd_idx_i     = 5'd0;
        opcode_ra_operand_i = 32'd0;
        opcode_rb_operand_i = 32'd0;
        hold_i              = 1'b0;
        flush_i             = 1'b0;
        #12;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_valid", 32'(writeback_valid_o), 32'd0);
        chk("reset_rd", 32'(writeback_rd_idx_o), 32'd0);
        chk("reset_value", writeback_value_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed cases from the plan.
        issue(OpDivu, 5'd1, 32'd100, 32'd7, 32, 1);
        issue(OpRemu, 5'd2, 32'd100, 32'd7, 32, 1);
        issue(OpDiv, 5'd3, -32'sd100, 32'd7, 32, 1);
        issue(OpRem, 5'd4, -32'sd100, 32'd7, 32, 1);
        issue(OpDiv, 5'd5, 32'd100, -32'sd7, 32, 1);
        issue(OpRem, 5'd6, 32'd100, -32'sd7, 32, 1);
        issue(OpDiv, 5'd7, -32'sd5, 32'd0, 32, 1);
        issue(OpRem, 5'd8, -32'sd5, 32'd0, 32, 1);
        issue(OpDivu, 5'd9, 32'h12345678, 32'd0, 32, 1);
        issue(OpDiv, 5'd10, 32'h80000000, 32'hFFFFFFFF, 32, 1);
        issue(OpRem, 5'd11, 32'h80000000, 32'hFFFFFFFF, 32, 1);

        // Hold for five cycles mid-run adds five cycles of latency.
        issue(OpDivu, 5'd12, 32'hFFFFFFFF, 32'd1, 37, 1);
        repeat (10) @(posedge clk_i);
        #1;
        hold_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        hold_i = 1'b0;

        // Non-divide opcode (MUL) and a held divide must both be ignored.
        while (busy_o) begin
            @(posedge clk_i);
            #1;
        end
        opcode_valid_i  = 1'b1;
        opcode_opcode_i = 32'h02000033;
        @(posedge clk_i);
        #1;
        chk("mul_ignored", 32'(busy_o), 32'd0);
        opcode_opcode_i = enc(OpDiv, 5'd3);
        hold_i          = 1'b1;
        @(posedge clk_i);
        #1;
        chk("held_divide_ignored", 32'(busy_o), 32'd0);
        hold_i         = 1'b0;
        opcode_valid_i = 1'b0;

        // Flush at iteration 10; a same-cycle divide must not be accepted.
        issue(OpDiv, 5'd13, 32'd1234567, 32'd89, 32, 0);
        repeat (9) @(posedge clk_i);
        #1;
        flush_i             = 1'b1;
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = enc(OpDivu, 5'd14);
        opcode_ra_operand_i = 32'd50;
        opcode_rb_operand_i = 32'd5;
        @(posedge clk_i);
        #1;
        flush_i        = 1'b0;
        opcode_valid_i = 1'b0;
        chk("busy_after_flush", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("flush_same_cycle_ignored", 32'(busy_o), 32'd0);
        issue(OpDivu, 5'd15, 32'd9, 32'd3, 32, 1);

        // A divide presented during DONE waits for the following cycle.
        issue(OpRemu, 5'd16, 32'd1000, 32'd33, 32, 1);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!writeback_valid_o && n < 100);
        chk("b2b_first_strobe_seen", 32'(writeback_valid_o), 32'd1);
        d                   = cyc;
        opcode_valid_i      = 1'b1;
        opcode_opcode_i     = enc(OpDiv, 5'd17);
        opcode_rd_idx_i     = 5'd17;
        opcode_ra_operand_i = 32'hFFFF0000;
        opcode_rb_operand_i = 32'd3;
        sb_q.push_back('{5'd17, ref_div(OpDiv, 32'hFFFF0000, 32'd3), d + 34});
        @(posedge clk_i);
        #1;
        chk("not_accepted_in_done", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        opcode_valid_i = 1'b0;
        chk("accepted_after_done", 32'(busy_o), 32'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom_range(0, 3)), 5'($urandom), pick(), pick(), 32, 1);
        end

        // Asynchronous reset mid-run clears outputs immediately.
        issue(OpDiv, 5'd20, 32'd77777, 32'd11, 32, 0);
        repeat (5) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_valid", 32'(writeback_valid_o), 32'd0);
        chk("async_rst_rd", 32'(writeback_rd_idx_o), 32'd0);
        chk("async_rst_value", writeback_value_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        chk("post_reset_idle", 32'(busy_o), 32'd0);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
